// File: rtl/btb_update_scheduler.sv
// Queues EX-stage BTB updates and drains them into the single-ported BTB write port when IF is idle.
// Optional zero-latency forwarding from an empty queue: define FROST_BTB_UPD_BYPASS_EN.
module btb_update_scheduler #(
    parameter int XLEN    = 32,
    parameter int Depth   = 4,
    parameter int PtrBits = $clog2(Depth)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_upd_valid,
    input  logic [XLEN-1:0]    i_upd_pc,
    input  logic [XLEN-1:0]    i_upd_target,
    input  logic               i_upd_taken,
    input  logic               i_btb_port_busy,
    input  logic               i_clear,
    output logic               o_btb_wr_en,
    output logic [XLEN-1:0]    o_btb_wr_pc,
    output logic [XLEN-1:0]    o_btb_wr_target,
    output logic               o_btb_wr_taken,
    output logic [PtrBits:0]   o_count,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_dropped
);

    logic [XLEN-1:0]  pc_q     [Depth];
    logic [XLEN-1:0]  target_q [Depth];
    logic             taken_q  [Depth];
    logic [Depth-1:0] valid_q, valid_d;
    logic [PtrBits-1:0] head_q, head_d, tail_q, tail_d;
    logic [PtrBits:0]   count_q, count_d;

    logic               upd_ok, deq, bypass, coalesce, enq_new, match_any;
    logic [PtrBits-1:0] match_idx;

    assign o_count = count_q;
    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == (PtrBits+1)'(Depth));
    assign upd_ok  = i_upd_valid && !i_clear;
    assign deq     = !o_empty && !i_btb_port_busy && !i_clear;

`ifdef FROST_BTB_UPD_BYPASS_EN
    assign bypass = o_empty && i_upd_valid && !i_btb_port_busy && !i_clear;
`else
    assign bypass = 1'b0;
`endif

    // At most one valid entry can hold a given PC, so the last hit is the only hit.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = 0; i < Depth; i++) begin
            if (valid_q[i] && (pc_q[i] == i_upd_pc)) begin
                match_any = 1'b1;
                match_idx = PtrBits'(i);
            end
        end
    end

    // A hit on the head that is leaving this cycle must re-enter at the tail.
    assign coalesce  = upd_ok && match_any && !(deq && (match_idx == head_q));
    assign enq_new   = upd_ok && !coalesce && !bypass && (!o_full || deq);
    assign o_dropped = upd_ok && !coalesce && !bypass && o_full && !deq;

    always_comb begin
        o_btb_wr_en     = deq || bypass;
        o_btb_wr_pc     = '0;
        o_btb_wr_target = '0;
        o_btb_wr_taken  = 1'b0;
        if (bypass) begin
            o_btb_wr_pc     = i_upd_pc;
            o_btb_wr_target = i_upd_target;
            o_btb_wr_taken  = i_upd_taken;
        end else if (deq) begin
            o_btb_wr_pc     = pc_q[head_q];
            o_btb_wr_target = target_q[head_q];
            o_btb_wr_taken  = taken_q[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        count_d = count_q + (PtrBits+1)'(enq_new) - (PtrBits+1)'(deq);
        if (i_clear) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            count_d = '0;
        end else begin
            if (deq) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PtrBits'(1);
            end
            // Ordered after the dequeue so a full queue doing both keeps the tail slot valid.
            if (enq_new) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + PtrBits'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: payload storage is not reset; valid bits and output gating keep stale data invisible.
    always_ff @(posedge i_clk) begin
        if (enq_new) begin
            pc_q[tail_q]     <= i_upd_pc;
            target_q[tail_q] <= i_upd_target;
            taken_q[tail_q]  <= i_upd_taken;
        end else if (coalesce) begin
            target_q[match_idx] <= i_upd_target;
            taken_q[match_idx]  <= i_upd_taken;
        end
    end

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Directed bench for btb_update_scheduler: per-cycle vector table plus reset, latency and reset-mid-drain sequences.
module tb_btb_update_scheduler;

    localparam int XLEN = 32;
    localparam int PB   = 2;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_upd_valid;
    logic [XLEN-1:0] i_upd_pc, i_upd_target;
    logic            i_upd_taken, i_btb_port_busy, i_clear;
    logic            o_btb_wr_en, o_btb_wr_taken, o_full, o_empty, o_dropped;
    logic [XLEN-1:0] o_btb_wr_pc, o_btb_wr_target;
    logic [PB:0]     o_count;

    int checks = 0;
    int errors = 0;

    btb_update_scheduler #(.XLEN(XLEN), .Depth(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_upd_valid(i_upd_valid),
        .i_upd_pc(i_upd_pc), .i_upd_target(i_upd_target), .i_upd_taken(i_upd_taken),
        .i_btb_port_busy(i_btb_port_busy), .i_clear(i_clear),
        .o_btb_wr_en(o_btb_wr_en), .o_btb_wr_pc(o_btb_wr_pc),
        .o_btb_wr_target(o_btb_wr_target), .o_btb_wr_taken(o_btb_wr_taken),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_dropped(o_dropped)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        busy;
        logic        clear;
        logic        e_wr;
        logic [31:0] e_pc;
        logic [31:0] e_tgt;
        logic        e_tk;
        logic        e_drop;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic valid, input logic [31:0] pc, input logic [31:0] tgt,
                               input logic taken, input logic busy, input logic clear,
                               input logic e_wr, input logic [31:0] e_pc, input logic [31:0] e_tgt,
                               input logic e_tk, input logic e_drop, input int e_cnt);
        vec_t r;
        r.valid = valid; r.pc = pc; r.tgt = tgt; r.taken = taken; r.busy = busy; r.clear = clear;
        r.e_wr = e_wr; r.e_pc = e_pc; r.e_tgt = e_tgt; r.e_tk = e_tk; r.e_drop = e_drop; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic drive(input logic valid, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic taken, input logic busy, input logic clear);
        i_upd_valid = valid; i_upd_pc = pc; i_upd_target = tgt;
        i_upd_taken = taken; i_btb_port_busy = busy; i_clear = clear;
    endtask

    task automatic check_vec(input string tag, input vec_t x);
        check({tag, ".wr_en"}, 32'(o_btb_wr_en), 32'(x.e_wr));
        if (x.e_wr) begin
            check({tag, ".wr_pc"}, o_btb_wr_pc, x.e_pc);
            check({tag, ".wr_target"}, o_btb_wr_target, x.e_tgt);
            check({tag, ".wr_taken"}, 32'(o_btb_wr_taken), 32'(x.e_tk));
        end
        check({tag, ".dropped"}, 32'(o_dropped), 32'(x.e_drop));
        check({tag, ".count"}, 32'(o_count), 32'(x.e_cnt));
        check({tag, ".empty"}, 32'(o_empty), 32'(x.e_cnt == 0));
        check({tag, ".full"}, 32'(o_full), 32'(x.e_cnt == 4));
    endtask

    initial begin
        // Busy queueing then in-order drain
        vecs.push_back(v(1, 'h100, 'h200, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 'h104, 'h204, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 'h108, 'h208, 1, 1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 'h100, 'h200, 1, 0, 3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 'h104, 'h204, 0, 0, 2));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 'h108, 'h208, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Coalesce into a single write carrying the latest target/taken
        vecs.push_back(v(1, 'h100, 'h200, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 'h100, 'h300, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 'h100, 'h300, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Fill, drop the fifth, then simultaneous enqueue+dequeue while full
        vecs.push_back(v(1, 'h100, 'h1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 'h104, 'h2, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 'h108, 'h3, 1, 1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 'h10c, 'h4, 0, 1, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 'h110, 'h5, 1, 1, 0, 0, 0, 0, 0, 1, 4));
        vecs.push_back(v(1, 'h200, 'h6, 1, 0, 0, 1, 'h100, 'h1, 1, 0, 4));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 'h104, 'h2, 0, 0, 4));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 'h108, 'h3, 1, 0, 3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 'h10c, 'h4, 0, 0, 2));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 'h200, 'h6, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Same PC as the head while it drains: becomes a new entry
        vecs.push_back(v(1, 'h300, 'h10, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 'h300, 'h11, 0, 0, 0, 1, 'h300, 'h10, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 'h300, 'h11, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Clear at count=3 with a concurrent push
        vecs.push_back(v(1, 'h400, 'h1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 'h404, 'h2, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 'h408, 'h3, 1, 1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 'h40c, 'h4, 1, 0, 1, 0, 0, 0, 0, 0, 3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Coalesce into a non-head entry while the head drains
        vecs.push_back(v(1, 'h500, 'h1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 'h504, 'h2, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 'h504, 'h3, 0, 0, 0, 1, 'h500, 'h1, 1, 0, 2));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 'h504, 'h3, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        drive(0, 0, 0, 0, 0, 0);
        i_rst_n = 1'b0;
        #12;
        check("reset.wr_en", 32'(o_btb_wr_en), 0);
        check("reset.wr_pc", o_btb_wr_pc, 0);
        check("reset.wr_target", o_btb_wr_target, 0);
        check("reset.count", 32'(o_count), 0);
        check("reset.empty", 32'(o_empty), 1);
        check("reset.full", 32'(o_full), 0);
        check("reset.dropped", 32'(o_dropped), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Latency: bypass forwards same cycle, otherwise one cycle later from the queue
        @(negedge i_clk);
        drive(1, 'h100, 'h200, 1, 0, 0);
        #1;
`ifdef FROST_BTB_UPD_BYPASS_EN
        check_vec("lat0", v(0, 0, 0, 0, 0, 0, 1, 'h100, 'h200, 1, 0, 0));
        @(negedge i_clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_vec("lat1", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
        check_vec("lat0", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge i_clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_vec("lat1", v(0, 0, 0, 0, 0, 0, 1, 'h100, 'h200, 1, 0, 1));
        @(negedge i_clk);
        #1;
        check_vec("lat2", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge i_clk);
            drive(vecs[k].valid, vecs[k].pc, vecs[k].tgt, vecs[k].taken, vecs[k].busy, vecs[k].clear);
            #1;
            check_vec($sformatf("vec%0d", k), vecs[k]);
        end

        // Async reset in the middle of a drain
        @(negedge i_clk);
        drive(1, 'h600, 'h1, 1, 1, 0);
        @(negedge i_clk);
        drive(1, 'h604, 'h2, 1, 1, 0);
        @(negedge i_clk);
        drive(1, 'h608, 'h3, 1, 1, 0);
        @(negedge i_clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("rstmid.pre_wr_en", 32'(o_btb_wr_en), 1);
        @(negedge i_clk);
        #1;
        check("rstmid.pre_count", 32'(o_count), 2);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rstmid.wr_en", 32'(o_btb_wr_en), 0);
        check("rstmid.wr_pc", o_btb_wr_pc, 0);
        check("rstmid.count", 32'(o_count), 0);
        check("rstmid.empty", 32'(o_empty), 1);
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b1;

        @(negedge i_clk);
        drive(1, 'h100, 'h200, 1, 0, 0);
        #1;
`ifdef FROST_BTB_UPD_BYPASS_EN
        check_vec("post0", v(0, 0, 0, 0, 0, 0, 1, 'h100, 'h200, 1, 0, 0));
        @(negedge i_clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_vec("post1", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
        check_vec("post0", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge i_clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_vec("post1", v(0, 0, 0, 0, 0, 0, 1, 'h100, 'h200, 1, 0, 1));
        @(negedge i_clk);
        #1;
        check_vec("post2", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_update_scheduler.md
Name: btb_update_scheduler

Overview:
- Buffers BTB update requests from the EX-stage branch redirect logic and drains them into the single-ported BTB write port.
- Drains only in cycles when the IF-stage lookup is not using the port.
- Coalesces repeated updates to the same PC and preserves program order otherwise.
- Sits between the EX-stage BTB update outputs and the BTB array, so EX never stalls on BTB port contention.

Parameters:
- XLEN, 32, address/target width
- Depth, 4, queue entries; power of two, >= 2
- PtrBits, $clog2(Depth), queue pointer width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_upd_valid  in  1  BTB update request from EX, single-cycle qualifier
- i_upd_pc  in  XLEN  PC of resolved instruction
- i_upd_target  in  XLEN  actual target
- i_upd_taken  in  1  actual taken
- i_btb_port_busy  in  1  BTB port owned by IF lookup this cycle; no write allowed
- i_clear  in  1  synchronous discard of all queued updates (BTB invalidate)
- o_btb_wr_en  out  1  BTB write strobe
- o_btb_wr_pc  out  XLEN  write PC
- o_btb_wr_target  out  XLEN  write target
- o_btb_wr_taken  out  1  write taken bit
- o_count  out  PtrBits+1  occupied entries (registered)
- o_full  out  1  o_count == Depth
- o_empty  out  1  o_count == 0
- o_dropped  out  1  combinational pulse: incoming update discarded this cycle

Behaviour:
- Reset (i_rst_n low, async):
  - queue empty, head/tail pointers 0, all entry valid bits 0.
  - o_count=0, o_empty=1, o_full=0, o_btb_wr_en=0, o_dropped=0.
  - wr_pc/target/taken=0.
- Storage: circular FIFO of {pc, target, taken} with head/tail pointers; pointers wrap modulo Depth.
- Dequeue (drain): o_btb_wr_en = !o_empty && !i_btb_port_busy && !i_clear.
  - Write fields come from the head entry.
  - Head advances on the same clock edge.
  - At most one write per cycle.
- Enqueue, in priority order, evaluated each cycle with i_upd_valid && !i_clear:
  1. Coalesce: the PC matches a valid queued entry that is not being dequeued this cycle. Overwrite that entry's target/taken in place; count unchanged. At most one entry can match, by invariant.
  2. The PC matches only the head, and the head is dequeuing this cycle. Treat as a new entry and append at tail.
  3. Otherwise append at tail if (!o_full || dequeue this cycle).
  4. Otherwise drop: o_dropped=1; queue unchanged.
- Count update: count_next = count + enq_new - deq. Simultaneous enqueue and dequeue keeps count constant, including when full.
- i_clear: pointers and count go to 0 next edge. Same-cycle write and enqueue are suppressed, and o_dropped=0.
- i_upd_valid=0: write fields are ignored, not sampled.
- Ordering: drained writes occur in first-enqueue order. A coalesced entry keeps its original position.
- Latency: without bypass, minimum 1 cycle from i_upd_valid to o_btb_wr_en.

Optional Feature:
- Macro: FROST_BTB_UPD_BYPASS_EN.
- Defined: when o_empty && i_upd_valid && !i_btb_port_busy && !i_clear, the input is forwarded combinationally to the write port. o_btb_wr_en=1 that cycle and nothing is enqueued (zero latency, count stays 0).
- Not defined: all updates are enqueued first, and the write port is driven only from the head entry (purely registered write data).

Test Plan:
- Bypass on, empty, busy=0; push pc=0x100 tgt=0x200 taken=1 -> same cycle wr_en=1, wr_pc=0x100, wr_target=0x200, count stays 0. Bypass off -> wr_en=1 one cycle later, count 1 then 0.
- busy=1 for 4 cycles; push pc 0x100, 0x104, 0x108 on consecutive cycles -> count=3, no writes. Busy drops -> writes 0x100, 0x104, 0x108 on 3 consecutive cycles, then empty=1.
- busy=1; push pc=0x100 tgt=0x200 taken=1, then pc=0x100 tgt=0x300 taken=0 -> count=1. After release, a single write pc=0x100 tgt=0x300 taken=0.
- Depth=4, busy=1; push 5 distinct PCs -> 5th gives o_dropped=1, count=4, full=1. Next cycle busy=0 with push pc=0x200 -> head written, 0x200 accepted, count stays 4.
- count=3, i_clear=1 with i_upd_valid=1 -> no write and no enqueue that cycle, count=0 next cycle, o_dropped=0.
- Assert i_rst_n low mid-drain (count=2), deasserted off-edge -> outputs 0 immediately, count=0. After release, a new push behaves as the first test.
